// File: rtl/dist_xfer_pkg.sv
// dist_xfer_pkg -- shared definitions for the distribution transfer unit.
//   state_t     : controller FSM states
//   req_t       : one buffered request (write flag, byte address, line payload)
//   addr_bad()  : true when a line address is misaligned or out of range
package dist_xfer_pkg;

  localparam int LINE_W          = 256;
  localparam int LINE_OFS_BITS   = 5;   // 32-byte lines
  localparam int ADDR_LIMIT_BITS = 12;  // data memory spans 4 KiB
  localparam int ADDR_W          = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[LINE_OFS_BITS-1:0] != '0) || (a[ADDR_W-1:ADDR_LIMIT_BITS] != '0);
  endfunction

endpackage

// File: rtl/dist_req_fifo.sv
// dist_req_fifo -- small synchronous FIFO for incoming requests.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : enqueue (ignored when full)
//   pop, pop_data     : dequeue (ignored when empty); pop_data is the head entry
//   full, empty       : occupancy flags
// Push and pop in the same cycle are both honoured.
module dist_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dist_xfer_unit.sv
// dist_xfer_unit -- moves 256-bit lines between a request/response port and a
// data memory that signals completion with a clk_stall high-then-low pulse.
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/ready/write/addr/data : request channel (buffered in a 2-entry FIFO)
//   rsp_valid/ready/data/err     : response channel (held until rsp_ready)
//   addr, dist_in, DMemRead, DMemWrite : data memory command, live only in ISSUE
//   dist_out, clk_stall          : data memory return line and busy flag
// Optional build macro DIST_XFER_STATS_EN adds saturating 16-bit counters
// stat_loads, stat_stores and stat_errs, bumped at each response handshake.
module dist_xfer_unit
  import dist_xfer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr,
  output logic              DMemRead,
  output logic              DMemWrite,
  output logic [LINE_W-1:0] dist_in,
  input  logic [LINE_W-1:0] dist_out,
  input  logic              clk_stall
`ifdef DIST_XFER_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [LINE_W-1:0] rsp_data_d;
  logic              rsp_err_d;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  req_t              req_in;
  req_t              fifo_head;
  req_t              work;
  logic              in_issue;

  assign req_in = '{write: req_write, addr: req_addr, data: req_data};

  // Reset empties the FIFO, but req_ready must also read 0 while rst is held.
  assign req_ready = ~fifo_full & ~rst;

  dist_req_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid & req_ready),
    .push_data(req_in),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (addr_bad(work.addr)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (clk_stall) begin
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!clk_stall) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = work.write ? '0 : dist_out;
          state_d    = RESP;
        end else if (cnt == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rsp_data <= rsp_data_d;
      rsp_err  <= rsp_err_d;
    end
  end

  // Working copy of the popped head; only read once state has left IDLE.
  always_ff @(posedge clk) begin
    if (pop) work <= fifo_head;
  end

  // Memory command is decoded from state so an asynchronous reset clears it at once.
  assign in_issue  = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign DMemRead  = in_issue & ~work.write;
  assign DMemWrite = in_issue & work.write;
  assign addr      = in_issue ? work.addr : '0;
  assign dist_in   = (in_issue & work.write) ? work.data : '0;

`ifdef DIST_XFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 16'd1;
      end else if (work.write) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dist_xfer_unit.sv
// tb_dist_xfer_unit -- directed self-checking bench for dist_xfer_unit.
// A small behavioural data memory answers each strobe with a clk_stall pulse
// (or never, when stuck) and logs strobe activity for the checks.
module tb_dist_xfer_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [255:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic         rsp_err;
  logic [31:0]  addr;
  logic         DMemRead;
  logic         DMemWrite;
  logic [255:0] dist_in;
  logic [255:0] dist_out;
  logic         clk_stall;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  int           cyc = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           both_cnt = 0;
  int           leak_cnt = 0;
  int           rsp_seen = 0;
  int           issue_cyc = 0;
  int           stall_left = 0;
  int           stall_len = 3;
  bit           stuck = 1'b0;
  logic [31:0]  last_addr = '0;
  logic [255:0] last_din = '0;

  localparam logic [255:0] PAT_A = {64{4'hA}};
  localparam logic [255:0] PAT_B = {8{32'hDEADBEEF}};

  dist_xfer_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .addr     (addr),
    .DMemRead (DMemRead),
    .DMemWrite(DMemWrite),
    .dist_in  (dist_in),
    .dist_out (dist_out),
    .clk_stall(clk_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (DMemRead) begin
      rd_cnt = rd_cnt + 1;
      last_addr = addr;
      issue_cyc = cyc;
    end
    if (DMemWrite) begin
      wr_cnt = wr_cnt + 1;
      last_addr = addr;
      last_din = dist_in;
      issue_cyc = cyc;
    end
    if (DMemRead && DMemWrite) both_cnt = both_cnt + 1;
    if (!DMemRead && !DMemWrite && (addr != '0 || dist_in != '0)) leak_cnt = leak_cnt + 1;
    if (rsp_valid) rsp_seen = rsp_seen + 1;
    if (rst) begin
      stall_left = 0;
      clk_stall = 1'b0;
    end else begin
      if ((DMemRead || DMemWrite) && !stuck) stall_left = stall_len;
      if (stall_left > 0) begin
        clk_stall = 1'b1;
        stall_left = stall_left - 1;
      end else begin
        clk_stall = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the request was accepted.
  task automatic send(input logic w, input logic [31:0] a, input logic [255:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at a negedge; waits for rsp_valid, samples it, completes the handshake.
  task automatic get_rsp(input string tag, output logic [255:0] d, output logic e,
                         output int at_cyc);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk({tag, "_timeout"}, 1'b0, 1'b1);
    d = rsp_data;
    e = rsp_err;
    at_cyc = cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [255:0] d;
    logic         e;
    int           t;
    int           rd0, wr0, seen0, n;

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    dist_out = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_strobes", {DMemRead, DMemWrite}, 2'b00);
    chk("rst_addr", addr, '0);
    chk("rst_dist_in", dist_in, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    // load 0x40
    dist_out = PAT_A;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b0, 32'h40, '0);
    get_rsp("ld40", d, e, t);
    chk("ld40_data", d, PAT_A);
    chk("ld40_err", e, 1'b0);
    chk("ld40_reads", rd_cnt - rd0, 1);
    chk("ld40_writes", wr_cnt - wr0, 0);
    chk("ld40_addr", last_addr, 32'h40);

    // store 0x20
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b1, 32'h20, 256'h1234);
    get_rsp("st20", d, e, t);
    chk("st20_data", d, '0);
    chk("st20_err", e, 1'b0);
    chk("st20_writes", wr_cnt - wr0, 1);
    chk("st20_reads", rd_cnt - rd0, 0);
    chk("st20_dist_in", last_din, 256'h1234);
    chk("st20_addr", last_addr, 32'h20);

    // misaligned and out-of-range loads
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b0, 32'h44, '0);
    get_rsp("ld44", d, e, t);
    chk("ld44_err", e, 1'b1);
    chk("ld44_data", d, '0);
    send(1'b0, 32'h1000, '0);
    get_rsp("ld1000", d, e, t);
    chk("ld1000_err", e, 1'b1);
    chk("ld1000_data", d, '0);
    chk("bad_addr_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

    // timeout: clk_stall never rises
    stuck = 1'b1;
    send(1'b0, 32'h80, '0);
    get_rsp("tmo", d, e, t);
    chk("tmo_err", e, 1'b1);
    chk("tmo_data", d, '0);
    chk("tmo_latency", t - issue_cyc - 1, 16);
    stuck = 1'b0;

    // three back-to-back requests with responses held off
    dist_out = PAT_B;
    send(1'b0, 32'h60, '0);
    send(1'b1, 32'h80, 256'h55);
    send(1'b0, 32'h1000, '0);
    chk("b2b_third_full", req_ready, 1'b0);
    repeat (10) @(negedge clk);
    get_rsp("b2b_1", d, e, t);
    chk("b2b_1_data", d, PAT_B);
    chk("b2b_1_err", e, 1'b0);
    get_rsp("b2b_2", d, e, t);
    chk("b2b_2_data", d, '0);
    chk("b2b_2_err", e, 1'b0);
    chk("b2b_2_dist_in", last_din, 256'h55);
    get_rsp("b2b_3", d, e, t);
    chk("b2b_3_data", d, '0);
    chk("b2b_3_err", e, 1'b1);

    // reset while in WAIT_LO
    stall_len = 8;
    send(1'b0, 32'h40, '0);
    n = 0;
    while (!DMemRead && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wlo_strobe_seen", DMemRead, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wlo_rst_ctrl", {req_ready, rsp_valid, rsp_err, DMemRead, DMemWrite}, 5'b0);
    chk("wlo_rst_rsp_data", rsp_data, '0);
    chk("wlo_rst_addr", addr, '0);
    chk("wlo_rst_dist_in", dist_in, '0);
    @(negedge clk);
    rst = 1'b0;
    stall_len = 3;
    seen0 = rsp_seen;
    rsp_ready = 1'b1;
    repeat (30) @(negedge clk);
    rsp_ready = 1'b0;
    chk("wlo_no_rsp", rsp_seen - seen0, 0);

    chk("never_both_strobes", both_cnt, 0);
    chk("idle_outputs_zero", leak_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dist_xfer_unit.md
DIST_XFER_UNIT -- requirements
Module: dist_xfer_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in WAIT_HI or WAIT_LO before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted on cycle where req_valid&req_ready.
REQ-006 SHALL have port req_write, input, 1: 1 = store line, 0 = load line.
REQ-007 SHALL have port req_addr, input, 32: byte address of the 256-bit line.
REQ-008 SHALL have port req_data, input, 256: store payload.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: response consumed on rsp_valid&rsp_ready.
REQ-011 SHALL have port rsp_data, output, 256: load result, zero for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1: misaligned, out-of-range or timeout.
REQ-013 SHALL have port addr, output, 32: line address to data memory.
REQ-014 SHALL have ports DMemRead and DMemWrite, output, 1 each: distribution read/write strobes to data memory.
REQ-015 SHALL have port dist_in, output, 256: store line to data memory.
REQ-016 SHALL have port dist_out, input, 256: line returned by data memory.
REQ-017 SHALL have port clk_stall, input, 1: data memory busy.

Function
REQ-018 SHALL buffer requests in a 2-entry FIFO; req_ready = FIFO not full; enqueue and dequeue in the same cycle are both honoured.
REQ-019 SHALL run FSM states IDLE, CHECK, ISSUE, WAIT_HI, WAIT_LO, RESP.
REQ-020 IDLE->CHECK when FIFO non-empty and no response is pending; head is popped into a working register.
REQ-021 CHECK SHALL flag error when req_addr[4:0]!=0 or req_addr[31:12]!=0 and go straight to RESP with rsp_err=1, with no strobe issued; otherwise ->ISSUE.
REQ-022 ISSUE SHALL assert exactly one of DMemRead/DMemWrite for exactly one cycle, with addr and dist_in valid that cycle, and then go to WAIT_HI.
REQ-023 WAIT_HI SHALL wait for clk_stall=1, then go to WAIT_LO.
REQ-024 WAIT_LO SHALL wait for clk_stall=0; for a load it SHALL capture dist_out on that edge into rsp_data; it then goes to RESP.
REQ-025 In WAIT_HI or WAIT_LO, a count reaching TIMEOUT_CYCLES SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-026 RESP SHALL hold rsp_valid=1 with stable data until rsp_ready, then go to IDLE; back-to-back throughput SHALL be one request per 6 cycles minimum.
REQ-027 addr, dist_in and the strobes SHALL be 0 outside ISSUE; the strobes are never asserted simultaneously.

Reset
REQ-028 rst SHALL immediately force IDLE, empty the FIFO, and set req_ready=0 while rst is high, rsp_valid=0, rsp_err=0, rsp_data=0, strobes=0, addr=0, dist_in=0 and counters=0.
REQ-029 Reset mid-transfer SHALL drop the in-flight request without a response.

Configuration
REQ-030 With DIST_XFER_STATS_EN defined, SHALL add outputs stat_loads, stat_stores and stat_errs (16 bits each, saturating, cleared by rst), incremented at RESP handshake; without the macro, these ports and their logic SHALL be absent.

Structure
REQ-031 A shared package dist_xfer_pkg SHALL hold the FSM state enum, LINE_W=256, LINE_OFS_BITS=5, and ADDR_LIMIT_BITS=12.
REQ-032 The FIFO SHALL be sub-module dist_req_fifo (parameterised width and depth 2).

Verification
REQ-033 Load 0x40 with the memory model returning 0xAA..AA -> one DMemRead pulse, addr=0x40, rsp_data=0xAA..AA, rsp_err=0.
REQ-034 Store 0x20 with data 0x1234 -> one DMemWrite pulse with dist_in=0x1234, then rsp_valid with rsp_err=0 and rsp_data=0.
REQ-035 Load 0x44 and load 0x1000 -> rsp_err=1 for each, with no strobe ever asserted.
REQ-036 Model holds clk_stall low permanently -> rsp_err=1 exactly 16 cycles after WAIT_HI entry.
REQ-037 Three requests back-to-back with rsp_ready=0 -> third sees req_ready=0; all three complete in order after rsp_ready=1.
REQ-038 rst asserted in WAIT_LO -> all outputs 0 the same cycle, and no response after release.
